// File: rtl/mem_data_dump_ctrl_if.sv
// mem_data_dump_ctrl_if: pipeline, debug-dump and data-memory signals of mem_data_dump_ctrl.
// slave is the controller's view, master is the surrounding pipeline/debug/memory side.
interface mem_data_dump_ctrl_if #(
    parameter int NB_ADDR = 5,
    parameter int NB_DATA = 32
);
    logic               i_pipe_read;
    logic               i_pipe_write;
    logic [NB_ADDR-1:0] i_pipe_addr;
    logic [NB_DATA-1:0] i_pipe_write_data;
    logic [NB_DATA-1:0] o_pipe_read_data;
    logic               i_dump_start;
    logic               i_dump_ready;
    logic               o_dump_valid;
    logic [NB_DATA-1:0] o_dump_data;
    logic [NB_ADDR-1:0] o_dump_addr;
    logic               o_dump_busy;
    logic               o_dump_done;
    logic               o_mem_enable;
    logic               o_mem_write;
    logic               o_mem_read;
    logic [NB_ADDR-1:0] o_mem_addr;
    logic [NB_DATA-1:0] o_mem_write_data;
    logic [NB_DATA-1:0] i_mem_read_data;
    modport slave (
        input  i_pipe_read, i_pipe_write, i_pipe_addr, i_pipe_write_data,
        input  i_dump_start, i_dump_ready, i_mem_read_data,
        output o_pipe_read_data, o_dump_valid, o_dump_data, o_dump_addr,
        output o_dump_busy, o_dump_done,
        output o_mem_enable, o_mem_write, o_mem_read, o_mem_addr, o_mem_write_data
    );
    modport master (
        output i_pipe_read, i_pipe_write, i_pipe_addr, i_pipe_write_data,
        output i_dump_start, i_dump_ready, i_mem_read_data,
        input  o_pipe_read_data, o_dump_valid, o_dump_data, o_dump_addr,
        input  o_dump_busy, o_dump_done,
        input  o_mem_enable, o_mem_write, o_mem_read, o_mem_addr, o_mem_write_data
    );
endinterface

// File: rtl/mem_data_dump_ctrl.sv
// mem_data_dump_ctrl: shares the data-memory port between the pipeline (priority) and a
// debug sequencer that reads every word and streams it out over valid/ready.
module mem_data_dump_ctrl #(
    parameter int NB_ADDR      = 5,
    parameter int NB_DATA      = 32,
    parameter int MEMORY_DEPTH = 32
) (
    input logic                 i_clock,
    input logic                 i_reset,
    mem_data_dump_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, SEND, DONE} state_t;
    localparam logic [NB_ADDR-1:0] LAST = NB_ADDR'(MEMORY_DEPTH - 1);
    state_t             state_q, state_d;
    logic [NB_ADDR-1:0] cnt_q, cnt_d;
    logic [NB_ADDR-1:0] addr_q, addr_d;
    logic [NB_DATA-1:0] data_q, data_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pipe_req;
    logic               dump_rd;
    assign pipe_req = bus.i_pipe_read | bus.i_pipe_write;
    assign dump_rd  = !pipe_req && state_q == ISSUE;
    // The port is forced quiet during reset so an aborted cycle cannot touch memory.
    assign bus.o_mem_enable     = !i_reset && (pipe_req || dump_rd);
    assign bus.o_mem_read       = !i_reset && (bus.i_pipe_read || dump_rd);
    assign bus.o_mem_write      = !i_reset && bus.i_pipe_write;
    assign bus.o_mem_addr       = i_reset ? '0 : pipe_req ? bus.i_pipe_addr : dump_rd ? cnt_q : '0;
    assign bus.o_mem_write_data = (i_reset || !pipe_req) ? '0 : bus.i_pipe_write_data;
    assign bus.o_pipe_read_data = bus.i_mem_read_data;
    assign bus.o_dump_valid     = valid_q;
    assign bus.o_dump_data      = data_q;
    assign bus.o_dump_addr      = addr_q;
    assign bus.o_dump_busy      = busy_q;
    assign bus.o_dump_done      = done_q;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                cnt_d   = bus.i_dump_start ? '0 : cnt_q;
                state_d = bus.i_dump_start ? ISSUE : IDLE;
            end
            ISSUE: state_d = pipe_req ? ISSUE : WAIT;
            WAIT: begin
                data_d  = bus.i_mem_read_data;
                addr_d  = cnt_q;
                state_d = SEND;
            end
            SEND: begin
                state_d = !bus.i_dump_ready ? SEND : cnt_q == LAST ? DONE : ISSUE;
                cnt_d   = (bus.i_dump_ready && cnt_q != LAST) ? cnt_q + 1'b1 : cnt_q;
            end
            default: state_d = IDLE;
        endcase
        valid_d = state_d == SEND;
        busy_d  = state_d != IDLE;
        done_d  = state_d == DONE;
    end
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: doc/mem_data_dump_ctrl.md
# mem_data_dump_ctrl

Memory-port controller in front of the MEM-stage data memory. It arbitrates the single memory port between the pipeline (fixed priority) and a debug dump sequencer. On request, the dump sequencer walks every data-memory word and streams it to the debug unit through a valid/ready handshake. The block sits between the MEM stage, the debug unit and the data memory; the memory is instantiated unchanged.

## Interface
Parameters:
- NB_ADDR, 5, memory address width
- NB_DATA, 32, data word width
- MEMORY_DEPTH, 32, number of words walked by a dump; must equal 2**NB_ADDR or less

Ports:
- i_clock  in  1  single clock, all state on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_pipe_read  in  1  MEM-stage read request
- i_pipe_write  in  1  MEM-stage write request
- i_pipe_addr  in  NB_ADDR  MEM-stage address
- i_pipe_write_data  in  NB_DATA  MEM-stage store data
- o_pipe_read_data  out  NB_DATA  memory read data, combinational copy of i_mem_read_data
- i_dump_start  in  1  start a dump; sampled only in IDLE
- i_dump_ready  in  1  debug unit accepts current word
- o_dump_valid  out  1  o_dump_data/o_dump_addr valid
- o_dump_data  out  NB_DATA  captured word
- o_dump_addr  out  NB_ADDR  address of current word
- o_dump_busy  out  1  high in every state except IDLE
- o_dump_done  out  1  one-cycle pulse after last word accepted
- o_mem_enable, o_mem_write, o_mem_read  out  1 each  memory controls
- o_mem_addr  out  NB_ADDR  memory address
- o_mem_write_data  out  NB_DATA  memory write data
- i_mem_read_data  in  NB_DATA  memory registered read data (1-cycle latency; zeroed when enabled without read; held when disabled)

## Operation
- FSM states: IDLE, ISSUE, WAIT, SEND, DONE. Address counter `cnt` (NB_ADDR bits).
- Port mux, evaluated combinationally every cycle:
  - pipe_req = i_pipe_read | i_pipe_write.
  - If pipe_req, the pipeline owns the port: enable=1, read/write/addr/data come from the pipeline. Read and write may both be asserted; both pass through.
  - Else, if state==ISSUE, the dump owns the port: enable=1, read=1, write=0, addr=cnt, write_data=0.
  - Else, enable=read=write=0 and addr/data=0. The memory holds its last read data.
- IDLE: if i_dump_start, set cnt=0 and go to ISSUE. Otherwise stay.
- ISSUE: if pipe_req, stay; the dump is stalled with no penalty beyond the lost cycle. Otherwise the read is issued and the state goes to WAIT.
- WAIT: the pipeline may use the port freely. At the clock edge, capture o_dump_data ← i_mem_read_data and o_dump_addr ← cnt, then go to SEND.
- SEND: o_dump_valid=1. Data and address are held stable until accepted. On i_dump_ready:
  - if cnt==MEMORY_DEPTH-1, go to DONE;
  - else cnt←cnt+1 and go to ISSUE.
- DONE: o_dump_done=1 for one cycle, then go to IDLE. cnt wraps to 0 on the next start.
- i_dump_start outside IDLE is ignored.
- A dump never writes memory. Pipeline writes during a dump are performed, so words dumped later reflect those writes.

## Timing
- Reset (i_reset high at an edge) forces IDLE, cnt=0, o_dump_valid=0, o_dump_data=0, o_dump_addr=0, o_dump_busy=0, o_dump_done=0.
- While i_reset is high, all o_mem_* are 0. Reset mid-dump aborts the dump with no done pulse.
- Pipeline read latency is unchanged at 1 cycle. o_pipe_read_data is valid in the cycle after the pipeline read and must be sampled then; a dump read may overwrite it one cycle later.
- Dump word cost: 3 cycles minimum (ISSUE, WAIT, SEND with ready high), plus 1 per pipeline-stall cycle in ISSUE, plus 1 per SEND cycle with ready low.
- An uncontended dump with ready tied high takes 3·MEMORY_DEPTH cycles from leaving IDLE to DONE; done then pulses 1 cycle later.
- o_dump_valid rises on the edge leaving WAIT and falls on the accepting edge. The handshake completes on any edge with valid & ready.

## Test plan
- Reset: drive outputs to garbage, assert i_reset for 2 cycles -> all dump outputs 0, busy 0, o_mem_enable 0.
- Uncontended dump: preload BRAM[k]=32'hA000_0000+k, pulse start, hold ready=1 -> 32 words, addr 0..31 with matching data, valid every 3rd cycle, done pulses once at cycle 97 after start.
- Pipeline priority: during a dump, hold i_pipe_read=1 addr=7 for 5 cycles while in ISSUE -> the dump issues nothing during those cycles, the pipeline receives BRAM[7] the next cycle, and the dump sequence is unchanged otherwise.
- Backpressure: hold ready=0 for 10 cycles at word 4 -> valid stays 1 with data/addr stable at 4, no memory access from the dump, resumes on ready.
- Write during dump: at word 2, pipeline writes 32'hDEAD_BEEF to addr 20 -> dumped word 20 = 32'hDEAD_BEEF.
- Reset mid-dump at word 10, then a new start -> no done pulse for the aborted dump; the new dump starts at addr 0; start pulses during busy are ignored.
